// File: rtl/sbox_lookup_engine.sv
// -----------------------------------------------------------------------------
// sbox_lookup_engine
//   Captures a 2**DW-entry S-box from the generator stream and builds the inverse
//   table while the entries arrive. It then substitutes streamed pixel bytes
//   through either the forward table (encrypt) or the inverse table (decrypt).
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   reload_i        synchronous pulse: drop the table and return to loading
//   load_valid_i    S-box beat present on load_data_i (no backpressure)
//   load_data_i     S-box entry; entry k is the k-th accepted beat
//   load_done_o     every entry captured, engine serving lookups
//   perm_error_o    sticky: the loaded table repeats a value
//   in_valid_i      pixel present on in_data_i / in_inverse_i
//   in_ready_o      engine accepts a pixel this cycle
//   in_data_i       pixel byte
//   in_inverse_i    0: forward lookup, 1: inverse lookup
//   out_valid_o     substituted byte present on out_data_o
//   out_ready_i     downstream accepts out_data_o
//   out_data_o      substituted byte
//   sub_count_o     completed output transfers, wraps modulo 2**COUNT_W
// -----------------------------------------------------------------------------
module sbox_lookup_engine #(
  parameter int DW      = 8,
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reload_i,
  input  logic               load_valid_i,
  input  logic [DW-1:0]      load_data_i,
  output logic               load_done_o,
  output logic               perm_error_o,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DW-1:0]      in_data_i,
  input  logic               in_inverse_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DW-1:0]      out_data_o,
  output logic [COUNT_W-1:0] sub_count_o
);

  localparam int          ENTRIES  = 2**DW;
  localparam logic [DW:0] LAST_IDX = (DW+1)'(ENTRIES - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [DW:0]          idx_q, idx_d;
  logic [ENTRIES-1:0]   seen_q, seen_d;
  logic                 perm_error_q, perm_error_d;
  logic                 load_done_q, load_done_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [COUNT_W-1:0]   sub_count_q, sub_count_d;

  logic [DW-1:0]        fwd_q [ENTRIES];
  logic [DW-1:0]        inv_q [ENTRIES];

  logic                 in_ready_s;
  logic                 load_beat_s;
  logic                 accept_s;
  logic                 xfer_s;
  logic [DW-1:0]        lookup_s;

  // Reload outranks any load or pixel beat offered in the same cycle.
  assign in_ready_s  = (state_q == ST_RUN) && (!out_valid_q || out_ready_i);
  assign load_beat_s = (state_q == ST_LOAD) && load_valid_i && !reload_i;
  assign accept_s    = in_valid_i && in_ready_s && !reload_i;
  assign xfer_s      = out_valid_q && out_ready_i;
  assign lookup_s    = in_inverse_i ? inv_q[in_data_i] : fwd_q[in_data_i];

  assign in_ready_o   = in_ready_s;
  assign load_done_o  = load_done_q;
  assign perm_error_o = perm_error_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign sub_count_o  = sub_count_q;

  // Table storage: forward entry at its beat index, inverse entry at its value.
  always_ff @(posedge clk) begin
    if (load_beat_s) begin
      fwd_q[idx_q[DW-1:0]] <= load_data_i;
      inv_q[load_data_i]   <= idx_q[DW-1:0];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      idx_q        <= {(DW+1){1'b0}};
      seen_q       <= {ENTRIES{1'b0}};
      perm_error_q <= 1'b0;
      load_done_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DW{1'b0}};
      sub_count_q  <= {COUNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seen_q       <= seen_d;
      perm_error_q <= perm_error_d;
      load_done_q  <= load_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sub_count_q  <= sub_count_d;
    end
  end

  // Next-state logic for the load/run FSM and the one-stage lookup pipeline.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seen_d       = seen_q;
    perm_error_d = perm_error_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    sub_count_d  = sub_count_q;

    if (reload_i) begin
      // A pending output byte is dropped and not counted.
      state_d      = ST_LOAD;
      idx_d        = {(DW+1){1'b0}};
      seen_d       = {ENTRIES{1'b0}};
      perm_error_d = 1'b0;
      out_valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_valid_i) begin
            seen_d[load_data_i] = 1'b1;
            // A value seen twice means the table cannot be inverted.
            if (seen_q[load_data_i]) begin
              perm_error_d = 1'b1;
            end else begin
              perm_error_d = perm_error_q;
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
              idx_d   = {(DW+1){1'b0}};
            end else begin
              idx_d   = idx_q + (DW+1)'(1);
            end
          end else begin
            idx_d = idx_q;
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            sub_count_d = sub_count_q + COUNT_W'(1);
          end else begin
            sub_count_d = sub_count_q;
          end
          if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = lookup_s;
          end else if (xfer_s) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = out_valid_q;
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end

    load_done_d = (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_sbox_lookup_engine.sv
module tb_sbox_lookup_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_inverse = 1'b0;
  logic        out_ready = 1'b0;

  logic        load_done, perm_error, in_ready, out_valid;
  logic [7:0]  out_data;
  logic [23:0] sub_count;

  logic        load_done4, perm_error4, in_ready4, out_valid4;
  logic [7:0]  out_data4;
  logic [3:0]  sub_count4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sbox_lookup_engine #(.DW(8), .COUNT_W(24)) dut (
    .clk(clk), .rst(rst), .reload_i(reload),
    .load_valid_i(load_valid), .load_data_i(load_data),
    .load_done_o(load_done), .perm_error_o(perm_error),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_inverse_i(in_inverse), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .sub_count_o(sub_count)
  );

  // Narrow counter instance, same stimulus, to exercise counter wrap.
  sbox_lookup_engine #(.DW(8), .COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .reload_i(reload),
    .load_valid_i(load_valid), .load_data_i(load_data),
    .load_done_o(load_done4), .perm_error_o(perm_error4),
    .in_valid_i(in_valid), .in_ready_o(in_ready4), .in_data_i(in_data),
    .in_inverse_i(in_inverse), .out_valid_o(out_valid4), .out_ready_i(out_ready),
    .out_data_o(out_data4), .sub_count_o(sub_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_tab [256];
  int          m_beats;
  bit          m_run, m_dup, m_ov, m_odk;
  logic [7:0]  m_od;
  int unsigned m_cnt;

  function automatic logic [7:0] inv_of(input logic [7:0] x);
    for (int k = 0; k < 256; k++) begin
      if (m_tab[k] == x) return 8'(k);
    end
    return 8'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_beats <= 0; m_dup <= 1'b0; m_ov <= 1'b0;
      m_od <= 8'h00; m_odk <= 1'b1; m_cnt <= 0;
    end else if (reload) begin
      m_run <= 1'b0; m_beats <= 0; m_dup <= 1'b0; m_ov <= 1'b0; m_odk <= 1'b0;
    end else if (!m_run) begin
      if (load_valid) begin
        bit d;
        d = 1'b0;
        for (int j = 0; j < m_beats; j++) if (m_tab[j] == load_data) d = 1'b1;
        if (d) m_dup <= 1'b1;
        m_tab[m_beats] <= load_data;
        if (m_beats == 255) begin
          m_run <= 1'b1; m_beats <= 0;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end else begin
      bit xfer, acc;
      xfer = m_ov && out_ready;
      acc  = in_valid && (!m_ov || out_ready);
      if (xfer) m_cnt <= m_cnt + 1;
      if (acc) begin
        m_ov <= 1'b1;
        if (in_inverse) begin
          m_od <= inv_of(in_data); m_odk <= !m_dup;
        end else begin
          m_od <= m_tab[in_data]; m_odk <= 1'b1;
        end
      end else if (xfer) begin
        m_ov <= 1'b0; m_odk <= 1'b0;
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    chk("load_done", {31'b0, load_done}, {31'b0, m_run});
    chk("perm_error", {31'b0, perm_error}, {31'b0, m_dup});
    chk("in_ready", {31'b0, in_ready}, {31'b0, (m_run && (!m_ov || out_ready))});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    if (m_odk) chk("out_data", {24'b0, out_data}, {24'b0, m_od});
    chk("sub_count", {8'b0, sub_count}, {8'b0, m_cnt[23:0]});
    chk("sub_count4", {28'b0, sub_count4}, {28'b0, m_cnt[3:0]});
    chk("out_valid4", {31'b0, out_valid4}, {31'b0, m_ov});
  end

  // ---------------- stimulus ----------------
  logic [7:0] ld_vals [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input bit gaps);
    for (int k = 0; k < 256; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          load_valid = 1'b0; in_valid = $urandom_range(0, 1); out_ready = $urandom_range(0, 1);
          tick();
        end
      end
      load_valid = 1'b1; load_data = ld_vals[k];
      tick();
    end
    load_valid = 1'b0; in_valid = 1'b0;
  endtask

  task automatic random_perm();
    logic [7:0] t;
    int j;
    for (int i = 0; i < 256; i++) ld_vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ld_vals[i]; ld_vals[i] = ld_vals[j]; ld_vals[j] = t;
    end
  endtask

  task automatic traffic(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      in_inverse = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic pixel(input logic [7:0] d, input logic inv);
    in_valid = 1'b1; in_data = d; in_inverse = inv;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("reset out_data", {24'b0, out_data}, 32'h0);
    rst = 1'b0;
    tick();

    // T1: reversed table, back-to-back load
    for (int k = 0; k < 256; k++) ld_vals[k] = 8'(255 - k);
    for (int k = 0; k < 255; k++) begin
      load_valid = 1'b1; load_data = ld_vals[k]; tick();
    end
    chk("T1 load_done before last", {31'b0, load_done}, 32'h0);
    load_data = ld_vals[255]; tick();
    load_valid = 1'b0;
    chk("T1 load_done", {31'b0, load_done}, 32'h1);
    chk("T1 perm_error", {31'b0, perm_error}, 32'h0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h00; in_inverse = 1'b0; tick();
    chk("T1 fwd 00", {24'b0, out_data}, 32'hFF);
    chk("T1 model fwd 00", {24'b0, m_od}, 32'hFF);
    in_data = 8'h10; in_inverse = 1'b1; tick();
    in_valid = 1'b0;
    chk("T1 inv 10", {24'b0, out_data}, 32'hEF);
    chk("T1 model inv 10", {24'b0, m_od}, 32'hEF);
    tick();

    // T2: stream 0..3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_inverse = 1'b0; tick();
      chk("T2 stream", {24'b0, out_data}, 32'(8'hFF - 8'(i)));
    end
    in_valid = 1'b0; tick(); tick();
    chk("T2 sub_count", {8'b0, sub_count}, 32'd6);

    // T3: backpressure
    pixel(8'h00, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("T3 hold data", {24'b0, out_data}, 32'hFF);
      chk("T3 in_ready low", {31'b0, in_ready}, 32'h0);
    end
    out_ready = 1'b1; tick();
    in_valid = 1'b0;
    chk("T3 next pixel", {24'b0, out_data}, 32'hFE);
    tick(); tick();
    chk("T3 sub_count", {8'b0, sub_count}, 32'd8);

    // T6: 17 transfers wrap a 4-bit counter to 1, then reload while stalled
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_inverse = $urandom_range(0, 1); tick();
    end
    in_valid = 1'b0; tick(); tick();
    chk("T6 wrap", {28'b0, sub_count4}, 32'd1);
    out_ready = 1'b0; pixel(8'h33, 1'b0);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("T6 out_valid dropped", {31'b0, out_valid}, 32'h0);
    chk("T6 count kept", {28'b0, sub_count4}, 32'd1);
    out_ready = 1'b1; tick();

    // T4: all-zero table
    for (int k = 0; k < 256; k++) ld_vals[k] = 8'h00;
    load_valid = 1'b1; load_data = 8'h00; tick();
    chk("T4 perm_error beat1", {31'b0, perm_error}, 32'h0);
    tick();
    chk("T4 perm_error beat2", {31'b0, perm_error}, 32'h1);
    for (int k = 2; k < 256; k++) tick();
    load_valid = 1'b0;
    chk("T4 load_done", {31'b0, load_done}, 32'h1);
    chk("T4 perm sticky", {31'b0, perm_error}, 32'h1);
    traffic(40);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("T4 reload perm", {31'b0, perm_error}, 32'h0);
    chk("T4 reload done", {31'b0, load_done}, 32'h0);

    // Random permutations with gapped loads and random traffic
    for (int r = 0; r < 3; r++) begin
      random_perm();
      load_table(1'b1);
      traffic(300);
      reload = 1'b1; tick(); reload = 1'b0;
    end

    // T5: reset after 100 beats, then identity load
    random_perm();
    for (int k = 0; k < 100; k++) begin
      load_valid = 1'b1; load_data = ld_vals[k]; tick();
    end
    load_valid = 1'b0;
    rst = 1'b1; tick();
    chk("T5 reset load_done", {31'b0, load_done}, 32'h0);
    rst = 1'b0; tick();
    for (int k = 0; k < 256; k++) ld_vals[k] = 8'(k);
    load_table(1'b0);
    out_ready = 1'b1;
    pixel(8'h5A, 1'b0);
    chk("T5 fwd 5A", {24'b0, out_data}, 32'h5A);
    pixel(8'h5A, 1'b1);
    chk("T5 inv 5A", {24'b0, out_data}, 32'h5A);
    traffic(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
